// File: rtl/axi_system_top_if.sv
// AXI4-Lite bus (5-bit byte address, 32-bit data) linking the dot-product
// master to its register-file slave.
interface axi_system_top_if;
  logic [4:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_system_top.sv
// Dot-product subsystem: an AXI4-Lite master reads REG0..REG5 from an internal
// register-file slave, then runs a 12-step unsigned 8x8 MAC.
// Optional macro DP_WRITEBACK_EN adds REG6 at 0x18 and writes the result back to it.
module axi_system_top_regs #(
  parameter logic [31:0] REG0_val = 32'h0000_0000,
  parameter logic [31:0] REG1_val = 32'h0000_0000,
  parameter logic [31:0] REG2_val = 32'h0000_0000,
  parameter logic [31:0] REG3_val = 32'h0000_0000,
  parameter logic [31:0] REG4_val = 32'h0000_0000,
  parameter logic [31:0] REG5_val = 32'h0000_0000
) (
  input logic             ACLK,
  input logic             ARESETN,
  axi_system_top_if.slave bus
);
`ifdef DP_WRITEBACK_EN
  localparam int NREGS = 7;
`else
  localparam int NREGS = 6;
`endif
  localparam logic [2:0] LAST_IDX = 3'(NREGS - 1);
  localparam logic [1:0] OKAY     = 2'b00;
  localparam logic [1:0] SLVERR   = 2'b10;

  logic [31:0] regs_q [NREGS];
  logic [31:0] regs_d [NREGS];
  logic        arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        awready_q, awready_d, bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;

  function automatic logic mapped(input logic [4:0] addr);
    return (addr[1:0] == 2'b00) && (addr[4:2] <= LAST_IDX);
  endfunction

  // AW and W are accepted together, only once both are valid.
  always_comb begin
    regs_d    = regs_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    awready_d = awready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;

    if (rvalid_q && bus.rready) rvalid_d = 1'b0;
    if (bus.arvalid && arready_q) begin
      arready_d = 1'b0;
      rvalid_d  = 1'b1;
      rdata_d   = mapped(bus.araddr) ? regs_q[bus.araddr[4:2]] : 32'h0;
      rresp_d   = mapped(bus.araddr) ? OKAY : SLVERR;
    end else if (bus.arvalid && !rvalid_q) begin
      arready_d = 1'b1;
    end

    if (bvalid_q && bus.bready) bvalid_d = 1'b0;
    if (bus.awvalid && bus.wvalid && awready_q) begin
      awready_d = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = mapped(bus.awaddr) ? OKAY : SLVERR;
      if (mapped(bus.awaddr)) regs_d[bus.awaddr[4:2]] = bus.wdata;
    end else if (bus.awvalid && bus.wvalid && !bvalid_q) begin
      awready_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      regs_q[0] <= REG0_val;
      regs_q[1] <= REG1_val;
      regs_q[2] <= REG2_val;
      regs_q[3] <= REG3_val;
      regs_q[4] <= REG4_val;
      regs_q[5] <= REG5_val;
`ifdef DP_WRITEBACK_EN
      regs_q[6] <= 32'h0;
`endif
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      rresp_q   <= OKAY;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      regs_q    <= regs_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.awready = awready_q;
  assign bus.wready  = awready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
endmodule

module axi_system_top #(
  parameter logic [31:0] REG0_val = 32'h0000_0000,
  parameter logic [31:0] REG1_val = 32'h0000_0000,
  parameter logic [31:0] REG2_val = 32'h0000_0000,
  parameter logic [31:0] REG3_val = 32'h0000_0000,
  parameter logic [31:0] REG4_val = 32'h0000_0000,
  parameter logic [31:0] REG5_val = 32'h0000_0000
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        start_signal,
  output logic [7:0]  DP_A,
  output logic [7:0]  DP_B,
  output logic [31:0] DP_RESULT
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, COMPUTE, WR_REQ, WR_RESP, DONE} state_t;

  axi_system_top_if bus ();

  axi_system_top_regs #(
    .REG0_val(REG0_val), .REG1_val(REG1_val), .REG2_val(REG2_val),
    .REG3_val(REG3_val), .REG4_val(REG4_val), .REG5_val(REG5_val)
  ) u_regs (
    .ACLK   (ACLK),
    .ARESETN(ARESETN),
    .bus    (bus.slave)
  );

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] opnd_q [6];
  logic [31:0] opnd_d [6];
  logic [4:0]  araddr_q, araddr_d;
  logic        arvalid_q, arvalid_d, rready_q, rready_d;
  logic        awvalid_q, awvalid_d, bready_q, bready_d;
  logic [7:0]  dp_a_q, dp_a_d, dp_b_q, dp_b_d;
  logic [31:0] dp_result_q, dp_result_d;
  logic [7:0]  a_byte, b_byte;
  logic [15:0] product;
  logic        unused_bus;

  // idx[3:2] picks the word, idx[1:0] the byte within it (LSB first).
  always_comb begin
    a_byte  = opnd_q[{1'b0, idx_q[3:2]}][{idx_q[1:0], 3'b000} +: 8];
    b_byte  = opnd_q[3'd3 + {1'b0, idx_q[3:2]}][{idx_q[1:0], 3'b000} +: 8];
    product = {8'h00, a_byte} * {8'h00, b_byte};
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    idx_d       = idx_q;
    opnd_d      = opnd_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awvalid_d   = awvalid_q;
    bready_d    = bready_q;
    dp_a_d      = dp_a_q;
    dp_b_d      = dp_b_q;
    dp_result_d = dp_result_q;

    unique case (state_q)
      IDLE: if (start_signal) begin
        dp_result_d = 32'h0;
        k_d         = 3'd0;
        araddr_d    = 5'h00;
        arvalid_d   = 1'b1;
        state_d     = RD_ADDR;
      end
      RD_ADDR: if (bus.arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = RD_DATA;
      end
      RD_DATA: if (bus.rvalid) begin
        rready_d    = 1'b0;
        opnd_d[k_q] = (bus.rresp == 2'b00) ? bus.rdata : 32'h0;
        if (k_q == 3'd5) begin
          idx_d   = 4'd0;
          state_d = COMPUTE;
        end else begin
          k_d       = k_q + 3'd1;
          araddr_d  = {k_q + 3'd1, 2'b00};
          arvalid_d = 1'b1;
          state_d   = RD_ADDR;
        end
      end
      COMPUTE: begin
        dp_a_d      = a_byte;
        dp_b_d      = b_byte;
        dp_result_d = dp_result_q + {16'h0000, product};
        idx_d       = idx_q + 4'd1;
        if (idx_q == 4'd11) begin
`ifdef DP_WRITEBACK_EN
          awvalid_d = 1'b1;
          state_d   = WR_REQ;
`else
          state_d   = DONE;
`endif
        end
      end
`ifdef DP_WRITEBACK_EN
      WR_REQ: if (bus.awready) begin
        awvalid_d = 1'b0;
        bready_d  = 1'b1;
        state_d   = WR_RESP;
      end
      WR_RESP: if (bus.bvalid) begin
        bready_d = 1'b0;
        state_d  = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      k_q         <= 3'd0;
      idx_q       <= 4'd0;
      opnd_q      <= '{default: 32'h0};
      araddr_q    <= 5'h00;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      dp_a_q      <= 8'h00;
      dp_b_q      <= 8'h00;
      dp_result_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      idx_q       <= idx_d;
      opnd_q      <= opnd_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      bready_q    <= bready_d;
      dp_a_q      <= dp_a_d;
      dp_b_q      <= dp_b_d;
      dp_result_q <= dp_result_d;
    end
  end

  assign bus.araddr  = araddr_q;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;
  assign bus.awaddr  = 5'h18;
  assign bus.wdata   = dp_result_q;
  assign bus.awvalid = awvalid_q;
  assign bus.wvalid  = awvalid_q;
  assign bus.bready  = bready_q;
  assign unused_bus  = ^{bus.awready, bus.wready, bus.bvalid, bus.bresp};

  assign DP_A      = dp_a_q;
  assign DP_B      = dp_b_q;
  assign DP_RESULT = dp_result_q;
endmodule

// File: tb/tb_axi_system_top.sv
// Bench for axi_system_top: four parameterised instances checked against a byte-level
// dot-product model, plus a standalone register-file slave driven with random AXI traffic.
module tb_axi_system_top;
`ifdef DP_WRITEBACK_EN
  localparam int LAT   = 44;
  localparam int NREGS = 7;
`else
  localparam int LAT   = 40;
  localparam int NREGS = 6;
`endif
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // Register sets per instance, listed REG5 first.
  localparam logic [3:0][5:0][31:0] PALL = {
    {32'hFEDCBA98, 32'h76543210, 32'hCAFEBABE, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF},
    {32'h0, 32'h0, 32'h08070605, 32'h0, 32'h0, 32'h04030201},
    {6{32'hFFFF_FFFF}},
    {32'h0, 32'h0001_0000, 32'h3, 32'h100, 32'h0, 32'h1}
  };
  localparam logic [5:0][31:0] SREG = {32'h6666_0006, 32'h5555_0005, 32'h4444_0004,
                                       32'h3333_0003, 32'h2222_0002, 32'h1111_0001};

  typedef struct {
    int          inst;
    logic [31:0] exp_r;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  start_v = 4'b0;
  logic [7:0]  dp_a [4];
  logic [7:0]  dp_b [4];
  logic [31:0] dp_r [4];
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    axi_system_top #(
      .REG0_val(PALL[g][0]), .REG1_val(PALL[g][1]), .REG2_val(PALL[g][2]),
      .REG3_val(PALL[g][3]), .REG4_val(PALL[g][4]), .REG5_val(PALL[g][5])
    ) u_dut (
      .ACLK(clk), .ARESETN(rst_n), .start_signal(start_v[g]),
      .DP_A(dp_a[g]), .DP_B(dp_b[g]), .DP_RESULT(dp_r[g])
    );
  end

  axi_system_top_if sbus ();

  axi_system_top_regs #(
    .REG0_val(SREG[0]), .REG1_val(SREG[1]), .REG2_val(SREG[2]),
    .REG3_val(SREG[3]), .REG4_val(SREG[4]), .REG5_val(SREG[5])
  ) u_sreg (
    .ACLK(clk), .ARESETN(rst_n), .bus(sbus.slave)
  );

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int n);
    return 8'((w >> (8 * n)) & 32'hFF);
  endfunction

  // Sum of a_i*b_i for i = 0..upto, mod 2^32.
  function automatic logic [31:0] model_sum(input int inst, input int upto);
    logic [31:0] s = 32'h0;
    for (int i = 0; i <= upto; i++)
      s += 32'(byte_of(PALL[inst][i / 4], i % 4)) * 32'(byte_of(PALL[inst][3 + i / 4], i % 4));
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int inst);
    @(negedge clk);
    start_v[inst] = 1'b1;
    @(negedge clk);
    start_v[inst] = 1'b0;
  endtask

  task automatic runEntry(input vec_t v, input bit trace, input int extra_at);
    int hits = 0;
    int exp_i [$];
    if (trace)
      for (int i = 0; i < 12; i++)
        if (byte_of(PALL[v.inst][i / 4], i % 4) != 8'h00) exp_i.push_back(i);
    applyStimulus(v.inst);
    for (int c = 0; c < LAT; c++) begin
      @(negedge clk);
      start_v[v.inst] = (c == extra_at);
      if (trace && dp_a[v.inst] != 8'h00) begin
        if (hits < exp_i.size()) begin
          checkOutput($sformatf("dut%0d trace DP_A #%0d", v.inst, hits), 32'(dp_a[v.inst]),
                      32'(byte_of(PALL[v.inst][exp_i[hits] / 4], exp_i[hits] % 4)));
          checkOutput($sformatf("dut%0d trace DP_B #%0d", v.inst, hits), 32'(dp_b[v.inst]),
                      32'(byte_of(PALL[v.inst][3 + exp_i[hits] / 4], exp_i[hits] % 4)));
          checkOutput($sformatf("dut%0d trace DP_RESULT #%0d", v.inst, hits), dp_r[v.inst],
                      model_sum(v.inst, exp_i[hits]));
        end
        hits++;
      end
    end
    start_v[v.inst] = 1'b0;
    if (trace) checkOutput($sformatf("dut%0d trace length", v.inst), 32'(hits), 32'(exp_i.size()));
    checkOutput($sformatf("dut%0d DP_RESULT", v.inst), dp_r[v.inst], v.exp_r);
    checkOutput($sformatf("dut%0d DP_A", v.inst), 32'(dp_a[v.inst]), 32'(v.exp_a));
    checkOutput($sformatf("dut%0d DP_B", v.inst), 32'(dp_b[v.inst]), 32'(v.exp_b));
  endtask

  task automatic axiRead(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    sbus.araddr  = addr;
    sbus.arvalid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!sbus.arready && n < 20);
    checkOutput("arready delay", 32'(n), 32'd1);
    @(negedge clk);
    sbus.arvalid = 1'b0;
    checkOutput("rvalid after AR", 32'(sbus.rvalid), 32'd1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    checkOutput("rvalid hold", 32'(sbus.rvalid), 32'd1);
    data = sbus.rdata;
    resp = sbus.rresp;
    sbus.rready = 1'b1;
    @(negedge clk);
    sbus.rready = 1'b0;
    checkOutput("rvalid clear", 32'(sbus.rvalid), 32'd0);
  endtask

  task automatic axiWrite(input logic [4:0] addr, input logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    sbus.awaddr  = addr;
    sbus.wdata   = data;
    sbus.awvalid = 1'b1;
    sbus.wvalid  = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!sbus.awready && n < 20);
    checkOutput("awready seen", 32'(sbus.awready), 32'd1);
    checkOutput("wready seen", 32'(sbus.wready), 32'd1);
    @(negedge clk);
    sbus.awvalid = 1'b0;
    sbus.wvalid  = 1'b0;
    n = 0;
    while (!sbus.bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bvalid seen", 32'(sbus.bvalid), 32'd1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    resp = sbus.bresp;
    sbus.bready = 1'b1;
    @(negedge clk);
    sbus.bready = 1'b0;
    checkOutput("bvalid clear", 32'(sbus.bvalid), 32'd0);
  endtask

  task automatic slaveTests();
    logic [31:0] model [8];
    logic [31:0] d, wd;
    logic [1:0]  r;
    int          idx;
    for (int i = 0; i < 8; i++) model[i] = (i < 6) ? SREG[i] : 32'h0;
    for (int i = 0; i < 8; i++) begin
      axiRead(5'(4 * i), d, r);
      checkOutput($sformatf("slave reset rdata @0x%02h", 4 * i), d, (i < NREGS) ? model[i] : 32'h0);
      checkOutput($sformatf("slave reset rresp @0x%02h", 4 * i), 32'(r), 32'((i < NREGS) ? OKAY : SLVERR));
    end
    for (int n = 0; n < 40; n++) begin
      idx = int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom;
        axiWrite(5'(4 * idx), wd, r);
        checkOutput($sformatf("slave bresp @0x%02h", 4 * idx), 32'(r), 32'((idx < NREGS) ? OKAY : SLVERR));
        if (idx < NREGS) model[idx] = wd;
      end else begin
        axiRead(5'(4 * idx), d, r);
        checkOutput($sformatf("slave rdata @0x%02h", 4 * idx), d, (idx < NREGS) ? model[idx] : 32'h0);
        checkOutput($sformatf("slave rresp @0x%02h", 4 * idx), 32'(r), 32'((idx < NREGS) ? OKAY : SLVERR));
      end
    end
  endtask

  initial begin
    sbus.awaddr = 5'h0; sbus.awvalid = 1'b0; sbus.wdata = 32'h0; sbus.wvalid = 1'b0;
    sbus.bready = 1'b0; sbus.araddr = 5'h0; sbus.arvalid = 1'b0; sbus.rready = 1'b0;

    vecs[0] = '{inst: 0, exp_r: 32'h0000_0003, exp_a: 8'h00, exp_b: 8'h00};
    vecs[1] = '{inst: 1, exp_r: 32'h000B_E80C, exp_a: 8'hFF, exp_b: 8'hFF};
    vecs[2] = '{inst: 2, exp_r: 32'h0000_0046, exp_a: 8'h00, exp_b: 8'h00};
    vecs[3] = '{inst: 3, exp_r: model_sum(3, 11),
                exp_a: byte_of(PALL[3][2], 3), exp_b: byte_of(PALL[3][5], 3)};

    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      checkOutput($sformatf("dut%0d reset DP_A", g), 32'(dp_a[g]), 32'h0);
      checkOutput($sformatf("dut%0d reset DP_B", g), 32'(dp_b[g]), 32'h0);
      checkOutput($sformatf("dut%0d reset DP_RESULT", g), dp_r[g], 32'h0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    slaveTests();

    for (int e = 0; e < 4; e++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      runEntry(vecs[e], e == 2, -1);
`ifdef DP_WRITEBACK_EN
      if (e == 0) checkOutput("dut0 REG6 writeback", gen_dut[0].u_dut.u_regs.regs_q[6], 32'h0000_0003);
`endif
    end

    // Starts while busy must be ignored; a start after completion recomputes from zero.
    for (int n = 0; n < 3; n++) runEntry(vecs[3], 1'b0, int'($urandom_range(3, 25)));
    runEntry(vecs[0], 1'b0, int'($urandom_range(3, 25)));
    runEntry(vecs[3], 1'b0, -1);

    // Reset in the middle of a computation.
    applyStimulus(3);
    repeat (22) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 4; g++) begin
      checkOutput($sformatf("dut%0d async reset DP_A", g), 32'(dp_a[g]), 32'h0);
      checkOutput($sformatf("dut%0d async reset DP_B", g), 32'(dp_b[g]), 32'h0);
      checkOutput($sformatf("dut%0d async reset DP_RESULT", g), dp_r[g], 32'h0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    checkOutput("dut3 idle after reset DP_A", 32'(dp_a[3]), 32'h0);
    checkOutput("dut3 idle after reset DP_B", 32'(dp_b[3]), 32'h0);
    checkOutput("dut3 idle after reset DP_RESULT", dp_r[3], 32'h0);
    runEntry(vecs[3], 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_system_top.md
Name: axi_system_top

Overview:
Self-contained dot-product subsystem. It holds an internal AXI4-Lite master and an internal AXI4-Lite slave register file (REG0..REG5), plus an 8x8 multiply-accumulate (MAC) datapath.
- A start pulse makes the master read all six registers over the internal AXI-Lite bus.
- The engine then computes an unsigned 12-element byte dot product, A·B.
- The MAC operands and the running result appear on top-level ports.

Parameters:
REG0_val  32'h0000_0000  reset value of REG0 (A bytes 0-3)
REG1_val  32'h0000_0000  reset value of REG1 (A bytes 4-7)
REG2_val  32'h0000_0000  reset value of REG2 (A bytes 8-11)
REG3_val  32'h0000_0000  reset value of REG3 (B bytes 0-3)
REG4_val  32'h0000_0000  reset value of REG4 (B bytes 4-7)
REG5_val  32'h0000_0000  reset value of REG5 (B bytes 8-11)

Ports:
ACLK  input  1  single clock; all logic on rising edge
ARESETN  input  1  asynchronous active-low reset
start_signal  input  1  start request, sampled high on a rising edge
DP_A  output  8  A operand of current/last MAC step
DP_B  output  8  B operand of current/last MAC step
DP_RESULT  output  32  accumulated dot product

Behaviour:
- Reset (ARESETN=0, asynchronous):
  - REGn <= REGn_val.
  - DP_A, DP_B, DP_RESULT <= 0.
  - All FSMs go to IDLE; all AXI valid/ready signals go to 0.
- Internal AXI-Lite bus: 32-bit data, 5-bit address. Not exposed on ports.
- Slave register map: REGk at byte address 4*k, k=0..5.
- Slave read timing:
  - ARREADY asserts one cycle after ARVALID; AR handshake in that cycle.
  - RVALID asserts the next cycle with RDATA=REGk and RRESP=OKAY; it holds until RREADY.
  - Unmapped address: RDATA=0, RRESP=SLVERR.
- Slave write channel: present. An AW+W pair writes a full word to REGk; BRESP=OKAY, or SLVERR if unmapped. Writes to unmapped addresses are dropped.
- Master FSM: IDLE -> RD_ADDR -> RD_DATA (repeated for k=0..5) -> COMPUTE -> DONE -> IDLE.
  - IDLE: a sampled start_signal=1 clears DP_RESULT to 0 and sets k=0.
  - RD_ADDR: drives ARADDR=4*k with ARVALID=1 until handshake.
  - RD_DATA: RREADY=1; captures RDATA into local operand buffer k.
  - An RRESP other than OKAY stores 0 for that word.
- COMPUTE: 12 cycles, index i=0..11, LSB byte of each word first.
  - a_i = byte (i%4) of buffer i/4; b_i = byte (i%4) of buffer 3+i/4.
  - Each cycle: DP_A<=a_i, DP_B<=b_i, DP_RESULT<=DP_RESULT+a_i*b_i.
  - Arithmetic: unsigned 8x8 -> 16-bit product, zero-extended, 32-bit accumulate wrapping mod 2^32.
- DONE: one cycle, then IDLE. Outputs hold their final values (DP_A/DP_B = byte 11 pair) until the next start.
- start_signal while not IDLE is ignored. No queuing.
- Latency: start to final DP_RESULT must be ≤ 40 cycles (nominal: 6 reads × 3 cycles + 12 compute + 2).
- A mid-operation reset aborts immediately and returns to reset values. A new start is required afterwards.

Optional Feature:
DP_WRITEBACK_EN:
- Defined:
  - Adds REG6 at address 0x18, reset value 0, readable and writable.
  - After COMPUTE, the master performs an AXI-Lite write of DP_RESULT to 0x18 (states WR_REQ, WR_RESP) before DONE.
  - Latency budget becomes ≤ 44 cycles.
- Undefined: no REG6. Address 0x18 is unmapped, giving SLVERR/0.

Test Plan:
1. REG0=1, REG1=0, REG2=0x100, REG3=3, REG4=0x10000, REG5=0; reset, pulse start -> after ≤40 cycles DP_RESULT=0x00000003, DP_A=0x00, DP_B=0x00.
2. All REGn=0xFFFFFFFF, start -> DP_RESULT=12×0xFE01=0x000BE80C, DP_A=0xFF, DP_B=0xFF.
3. REG0=0x04030201, REG3=0x08070605, others 0 -> DP_RESULT=70 (0x46). Monitor DP_A sequence 01,02,03,04,00… with the matching DP_B.
4. Second start_signal pulse during COMPUTE -> ignored; result identical to a single run. A start after DONE recomputes from 0 (same value, no accumulation across runs).
5. Assert ARESETN low mid-COMPUTE -> DP_A/DP_B/DP_RESULT=0 immediately; no output change until a new start.
6. With DP_WRITEBACK_EN defined, scenario 1 -> internal REG6 reads back 0x00000003. Without it, a read of 0x18 returns SLVERR with data 0.
